mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx.sv | 198 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and a sticky overflow flag.
// A byte pushed into an idle, empty TX path starts its frame one cycle later. Writes to a full FIFO are dropped.

module mmio_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // The caller qualifies push/pop. A push while full is legal only alongside a pop.
  // In that case the write lands in the slot being read out on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
endmodule

module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] in_data,
  input  logic        read_mem,
  input  logic        write_mem,
  output logic [31:0] out_data,
  output logic        tx,
  output logic        irq
);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [15:0]   baud_cnt, baud_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          overflow;

  logic          sel, wr_txdata, wr_status;
  logic          fifo_push, fifo_pop;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full;
  logic          baud_end, tx_active;
  logic [31:0]   status;
  logic          unused_bits;

  assign sel       = (addr[31:3] == BASE_ADDR[31:3]);
  assign wr_txdata = write_mem && sel && !addr[2];
  assign wr_status = write_mem && sel &&  addr[2];

  // A full FIFO still accepts a byte on the edge the FSM pops its head.
  assign fifo_push = wr_txdata && (!fifo_full || fifo_pop);

  mmio_uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (in_data[7:0]),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign baud_end = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_n  = state;
    baud_n   = baud_cnt;
    bit_n    = bit_cnt;
    shift_n  = shift;
    fifo_pop = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_n  = fifo_head;
          baud_n   = '0;
          bit_n    = '0;
          state_n  = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_n  = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_n  = '0;
          shift_n = {1'b0, shift[7:1]};
          bit_n   = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_n = STOP;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_n = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_n  = fifo_head;
            bit_n    = '0;
            state_n  = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // tx is registered from next-state values so the line never glitches.
    if (state_n == START)     tx_n = 1'b0;
    else if (state_n == DATA) tx_n = shift_n[0];
    else                      tx_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      tx       <= tx_n;
    end
  end

  // A dropped push and a clear on the same edge leave overflow set.
  always_ff @(posedge clk) begin
    if (reset)                                  overflow <= 1'b0;
    else if (wr_txdata && fifo_full && !fifo_pop) overflow <= 1'b1;
    else if (wr_status && in_data[3])           overflow <= 1'b0;
  end

  assign tx_active = (state != IDLE);
  assign status    = {23'd0, 5'(fifo_count), overflow, tx_active, fifo_empty, fifo_full};
  assign out_data  = (read_mem && sel && addr[2]) ? status : 32'h0;
  assign irq       = fifo_empty && (state == IDLE);

  assign unused_bits = ^{addr[1:0], in_data[31:8]};
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register decode table plus framed-serial corner sequences.

module tb_mmio_uart_tx;
  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] in_data;
  logic        read_mem;
  logic        write_mem;
  logic [31:0] out_data;
  logic        tx;
  logic        irq;

  int n_cmp  = 0;
  int n_fail = 0;

  mmio_uart_tx dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .in_data   (in_data),
    .read_mem  (read_mem),
    .write_mem (write_mem),
    .out_data  (out_data),
    .tx        (tx),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    in_data   = d;
    write_mem = 1'b1;
    tick();
    write_mem = 1'b0;
    addr      = '0;
    in_data   = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr     = a;
    read_mem = 1'b1;
    #1;
    d        = out_data;
    read_mem = 1'b0;
    addr     = '0;
  endtask

  // Expected line level t cycles into a 160-cycle frame of byte b.
  function automatic logic exp_tx(input logic [7:0] b, input int t);
    if (t < 16)  return 1'b0;
    if (t < 144) return b[(t - 16) / 16];
    return 1'b1;
  endfunction

  initial begin
    logic [31:0] rd;
    logic [7:0]  frames[5];
    logic        bad;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,  32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_1004, 32'h0,  32'h2};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_1007, 32'h0,  32'h2};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_1008, 32'h0,  32'h0};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_1004, 32'h0,  32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,  32'h0};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_1008, 32'hFF, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_1004, 32'h0,  32'h2};
    vecs[8] = '{1'b1, 1'b1, 32'h0000_1004, 32'h8,  32'h2};
    vecs[9] = '{1'b1, 1'b0, 32'h0000_1005, 32'h0,  32'h2};

    reset = 1'b1; addr = '0; in_data = '0; read_mem = 1'b0; write_mem = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_irq", {31'd0, irq}, 32'd1);
    bus_read(32'h1004, rd);
    check("reset_status", rd, 32'h2);

    // Register decode table; each row is held for one clock edge.
    for (int i = 0; i < 10; i++) begin
      addr      = vecs[i].a;
      in_data   = vecs[i].d;
      read_mem  = vecs[i].rd;
      write_mem = vecs[i].wr;
      #1;
      check($sformatf("decode_row%0d", i), out_data, vecs[i].exp);
      tick();
      read_mem = 1'b0; write_mem = 1'b0; addr = '0; in_data = '0;
    end
    check("decode_no_frame_irq", {31'd0, irq}, 32'd1);

    // Single frame of 0x55 with exact edge timing.
    do_reset();
    bus_write(32'h1000, 32'hFFFF_FF55);
    check("f55_tx_before_start", {31'd0, tx}, 32'd1);
    bus_read(32'h1004, rd);
    check("f55_status_queued", rd, 32'h10);
    for (int t = 0; t < 160; t++) begin
      tick();
      check($sformatf("f55_tx_t%0d", t), {31'd0, tx}, {31'd0, exp_tx(8'h55, t)});
      if (t == 0) begin
        bus_read(32'h1004, rd);
        check("f55_status_active", rd, 32'h6);
      end
    end
    check("f55_irq_in_stop", {31'd0, irq}, 32'd0);
    tick();
    check("f55_irq_after", {31'd0, irq}, 32'd1);
    check("f55_tx_idle", {31'd0, tx}, 32'd1);

    // Three back-to-back frames with no idle gap.
    do_reset();
    frames[0] = 8'hA1; frames[1] = 8'hB2; frames[2] = 8'hC3;
    bus_write(32'h1000, 32'hA1);
    bus_write(32'h1000, 32'hB2);
    bus_write(32'h1000, 32'hC3);
    bus_read(32'h1004, rd);
    check("b2b_status_count2", rd, 32'h24);
    bad = 1'b0;
    for (int t = 1; t < 480; t++) begin
      if (tx !== exp_tx(frames[t / 160], t % 160)) bad = 1'b1;
      tick();
    end
    check("b2b_frames", {31'd0, bad}, 32'd0);
    check("b2b_irq_after", {31'd0, irq}, 32'd1);

    // Overflow while busy, clear, then push on the STOP->START pop edge.
    do_reset();
    bus_write(32'h1000, 32'h11);
    tick();
    bus_write(32'h1000, 32'h21);
    bus_write(32'h1000, 32'h32);
    bus_write(32'h1000, 32'h43);
    bus_write(32'h1000, 32'h54);
    bus_write(32'h1000, 32'h65);
    bus_read(32'h1004, rd);
    check("ovf_status", rd, 32'h4D);
    bus_write(32'h1004, 32'h8);
    bus_read(32'h1004, rd);
    check("ovf_cleared", rd, 32'h45);
    for (int i = 0; i < 153; i++) tick();
    bus_read(32'h1004, rd);
    check("popedge_before", rd, 32'h45);
    bus_write(32'h1000, 32'h77);
    bus_read(32'h1004, rd);
    check("popedge_after", rd, 32'h45);
    frames[0] = 8'h21; frames[1] = 8'h32; frames[2] = 8'h43;
    frames[3] = 8'h54; frames[4] = 8'h77;
    bad = 1'b0;
    for (int t = 0; t < 800; t++) begin
      if (tx !== exp_tx(frames[t / 160], t % 160)) bad = 1'b1;
      tick();
    end
    check("popedge_frames", {31'd0, bad}, 32'd0);
    check("popedge_irq_after", {31'd0, irq}, 32'd1);

    // Reset during DATA bit 3, with a queued byte and a simultaneous write.
    do_reset();
    bus_write(32'h1000, 32'h5A);
    bus_write(32'h1000, 32'h33);
    for (int i = 0; i < 70; i++) tick();
    check("rst_mid_bit3", {31'd0, tx}, 32'd1);
    for (int i = 0; i < 8; i++) tick();
    reset = 1'b1; write_mem = 1'b1; addr = 32'h1000; in_data = 32'h99;
    tick();
    reset = 1'b0; write_mem = 1'b0; addr = '0; in_data = '0;
    check("rst_mid_tx", {31'd0, tx}, 32'd1);
    check("rst_mid_irq", {31'd0, irq}, 32'd1);
    bus_read(32'h1004, rd);
    check("rst_mid_status", rd, 32'h2);
    bad = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (tx !== 1'b1) bad = 1'b1;
      tick();
    end
    check("rst_no_frames", {31'd0, bad}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
